// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the pipelined instruction memory.
//   NOP           : all-zero instruction word written by the clear sweep and
//                   returned for out-of-range fetches (cast to DATA_W at use).
//   imem_state_t  : CLEAR while the sweep runs, RUN once the store is usable.
// -----------------------------------------------------------------------------
package imem_pkg;

  localparam int NOP_W = 32;
  localparam logic [NOP_W-1:0] NOP = '0;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } imem_state_t;

endpackage

// File: rtl/imem_array.sv
// -----------------------------------------------------------------------------
// imem_array
// Single-write-port, single-read-port synchronous RAM with read-first ordering.
// The caller guarantees that both addresses are below DEPTH whenever the
// matching enable is high.
//   clk      : rising-edge clock
//   rst      : synchronous, active-high; clears only the read-data register
//   we       : write strobe, mem[wr_addr] <= wr_data at the edge
//   wr_addr  : write word address
//   wr_data  : write data
//   re       : read strobe, rd_data <= mem[rd_addr] at the edge
//   rd_addr  : read word address
//   rd_data  : registered read data, holds while re is low
// -----------------------------------------------------------------------------
module imem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage write. No reset here: contents are cleared by the sweep that the
  // top level drives through this same port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[IDX_W'(wr_addr)] <= wr_data;
    end
  end

  // Registered read. Because the write above is non-blocking, a read and a
  // write to the same word in one cycle return the old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (re) begin
      rd_data <= mem[IDX_W'(rd_addr)];
    end
  end

endmodule

// File: rtl/instr_mem_pl.sv
// -----------------------------------------------------------------------------
// instr_mem_pl
// Synchronous-read instruction memory with a valid/ready fetch port, a
// registered response that holds under back-pressure, and a run-time write
// port for program loading. After reset it sweeps every word to NOP before
// accepting any traffic.
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   req_valid  : fetch request valid
//   req_addr   : fetch word address
//   req_ready  : fetch accepted when req_valid && req_ready
//   rsp_valid  : response valid
//   rsp_instr  : fetched instruction (NOP for addresses >= DEPTH)
//   rsp_ready  : consumer accepts the response
//   wr_en      : write strobe
//   wr_addr    : write word address (writes at >= DEPTH are dropped)
//   wr_data    : write data
//   wr_ready   : write taken when wr_en && wr_ready
//   init_done  : clear sweep finished
// -----------------------------------------------------------------------------
module instr_mem_pl
  import imem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_instr,
  input  logic              rsp_ready,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              init_done
);

  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

  imem_state_t       state;
  imem_state_t       state_next;
  logic [ADDR_W-1:0] clr_cnt;
  logic              clearing;
  logic              accept;
  logic              req_in_range;
  logic              wr_in_range;
  logic              wr_take;
  logic              rsp_oor;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] rd_data;

  // Range checks are done one bit wider so DEPTH == 2**ADDR_W works.
  assign req_in_range = {1'b0, req_addr} < DEPTH_EXT;
  assign wr_in_range  = {1'b0, wr_addr}  < DEPTH_EXT;

  assign accept  = req_valid && req_ready;
  assign wr_take = wr_en && wr_ready && wr_in_range;

  // State register and clear counter. The counter only advances during the
  // sweep, so its value after reaching RUN is irrelevant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_next;
      if (clearing) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  // Next state: leave CLEAR on the cycle that writes the last word.
  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clr_cnt == LAST_IDX) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = CLEAR;
    endcase
  end

  // State outputs. req_ready is the only combinational input-to-output path:
  // a held response frees the slot in the same cycle the consumer takes it.
  always_comb begin
    clearing  = 1'b0;
    init_done = 1'b0;
    wr_ready  = 1'b0;
    req_ready = 1'b0;
    case (state)
      CLEAR: clearing = 1'b1;
      RUN: begin
        init_done = 1'b1;
        wr_ready  = 1'b1;
        req_ready = !rsp_valid || rsp_ready;
      end
      default: clearing = 1'b0;
    endcase
  end

  // Response handshake. rsp_oor remembers that the accepted fetch was out of
  // range so the output shows NOP without touching the RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_oor   <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_oor   <= !req_in_range;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign rsp_instr = rsp_oor ? DATA_W'(NOP) : rd_data;

  // The sweep and the run-time write share the single RAM write port; they
  // never overlap because wr_ready is low during CLEAR.
  assign mem_we      = clearing || wr_take;
  assign mem_wr_addr = clearing ? clr_cnt : wr_addr;
  assign mem_wr_data = clearing ? DATA_W'(NOP) : wr_data;

  imem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we      (mem_we),
    .wr_addr (mem_wr_addr),
    .wr_data (mem_wr_data),
    .re      (accept && req_in_range),
    .rd_addr (req_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_instr_mem_pl.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_pl
// Scoreboard bench for instr_mem_pl. Instance 0 uses DEPTH = 256, instance 1
// uses DEPTH = 200 for the out-of-range cases. Stimulus pushes the expected
// instruction when a fetch is accepted; a monitor per instance pops and
// compares whenever a response is consumed (rsp_valid && rsp_ready).
// -----------------------------------------------------------------------------
module tb_instr_mem_pl;

  logic clk = 1'b0;
  logic rst;

  logic        req_valid [2];
  logic [7:0]  req_addr  [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_instr [2];
  logic        rsp_ready [2];
  logic        wr_en     [2];
  logic [7:0]  wr_addr   [2];
  logic [31:0] wr_data   [2];
  logic        wr_ready  [2];
  logic        init_done [2];

  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  instr_mem_pl #(.ADDR_W(8), .DATA_W(32), .DEPTH(256)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid[0]),
    .req_addr  (req_addr[0]),
    .req_ready (req_ready[0]),
    .rsp_valid (rsp_valid[0]),
    .rsp_instr (rsp_instr[0]),
    .rsp_ready (rsp_ready[0]),
    .wr_en     (wr_en[0]),
    .wr_addr   (wr_addr[0]),
    .wr_data   (wr_data[0]),
    .wr_ready  (wr_ready[0]),
    .init_done (init_done[0])
  );

  instr_mem_pl #(.ADDR_W(8), .DATA_W(32), .DEPTH(200)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid[1]),
    .req_addr  (req_addr[1]),
    .req_ready (req_ready[1]),
    .rsp_valid (rsp_valid[1]),
    .rsp_instr (rsp_instr[1]),
    .rsp_ready (rsp_ready[1]),
    .wr_en     (wr_en[1]),
    .wr_addr   (wr_addr[1]),
    .wr_data   (wr_data[1]),
    .wr_ready  (wr_ready[1]),
    .init_done (init_done[1])
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Inputs change 1 time unit after the falling edge, well away from posedge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pushExp(input int sel, input logic [31:0] value);
    if (sel == 0) exp_q0.push_back(value);
    else          exp_q1.push_back(value);
  endtask

  // Pops the oldest expectation of one instance and compares the response.
  task automatic monitorPop(input int sel);
    logic [31:0] want;
    if (sel == 0) begin
      if (exp_q0.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL dut0 unexpected response: got 0x%08h, expected none", rsp_instr[0]);
      end else begin
        want = exp_q0.pop_front();
        checkOutput("dut0 rsp_instr", rsp_instr[0], want);
      end
    end else begin
      if (exp_q1.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL dut1 unexpected response: got 0x%08h, expected none", rsp_instr[1]);
      end else begin
        want = exp_q1.pop_front();
        checkOutput("dut1 rsp_instr", rsp_instr[1], want);
      end
    end
  endtask

  // Monitors sample just before each rising edge: a response seen valid and
  // ready here is consumed at that edge.
  always begin
    @(negedge clk);
    #4;
    if (rsp_valid[0] === 1'b1 && rsp_ready[0] === 1'b1) monitorPop(0);
  end

  always begin
    @(negedge clk);
    #4;
    if (rsp_valid[1] === 1'b1 && rsp_ready[1] === 1'b1) monitorPop(1);
  end

  // Writes one word through the load port of the selected instance.
  task automatic writeWord(input int sel, input logic [7:0] addr, input logic [31:0] data);
    wr_en[sel]   = 1'b1;
    wr_addr[sel] = addr;
    wr_data[sel] = data;
    #1;
    checkOutput("wr_ready", {31'b0, wr_ready[sel]}, 32'd1);
    tick();
    wr_en[sel] = 1'b0;
  endtask

  // Issues a fetch and waits (bounded) for acceptance; the expected word is
  // queued at the accepting edge. req_valid is left high for back-to-back use.
  task automatic applyStimulus(input int sel, input logic [7:0] addr, input logic [31:0] exp_word);
    logic accepted;
    accepted       = 1'b0;
    req_valid[sel] = 1'b1;
    req_addr[sel]  = addr;
    for (int i = 0; i < 50 && !accepted; i++) begin
      #1;
      if (req_ready[sel]) begin
        pushExp(sel, exp_word);
        accepted = 1'b1;
      end
      tick();
    end
    checkOutput("fetch accepted", {31'b0, accepted}, 32'd1);
  endtask

  task automatic reqIdle(input int sel);
    req_valid[sel] = 1'b0;
  endtask

  // Counts edges after reset release until instance sel reports init_done.
  task automatic waitInit(input int sel, output int cycles);
    cycles = 0;
    for (int n = 1; n <= 400; n++) begin
      tick();
      if (init_done[sel]) begin
        cycles = n;
        break;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt0;
    int cnt1;

    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0;
      req_addr[s]  = '0;
      rsp_ready[s] = 1'b1;
      wr_en[s]     = 1'b0;
      wr_addr[s]   = '0;
      wr_data[s]   = '0;
    end

    // Reset: every output low on both instances.
    repeat (3) tick();
    for (int s = 0; s < 2; s++) begin
      checkOutput("reset req_ready", {31'b0, req_ready[s]}, 32'd0);
      checkOutput("reset rsp_valid", {31'b0, rsp_valid[s]}, 32'd0);
      checkOutput("reset rsp_instr", rsp_instr[s], 32'd0);
      checkOutput("reset wr_ready",  {31'b0, wr_ready[s]},  32'd0);
      checkOutput("reset init_done", {31'b0, init_done[s]}, 32'd0);
    end

    // Clear sweep: dut0 sees a write to 5 and a fetch throughout, both ignored.
    rst          = 1'b0;
    wr_en[0]     = 1'b1;
    wr_addr[0]   = 8'h05;
    wr_data[0]   = 32'hFFFF_FFFF;
    req_valid[0] = 1'b1;
    req_addr[0]  = 8'h05;
    cnt0 = 0;
    cnt1 = 0;
    for (int n = 1; n <= 400; n++) begin
      tick();
      if (init_done[1] && cnt1 == 0) cnt1 = n;
      if (init_done[0]) begin
        cnt0 = n;
        break;
      end
    end
    wr_en[0] = 1'b0;
    reqIdle(0);
    checkOutput("init_done latency dut0", cnt0, 32'd256);
    checkOutput("init_done latency dut1", cnt1, 32'd200);
    checkOutput("run wr_ready", {31'b0, wr_ready[0]}, 32'd1);
    applyStimulus(0, 8'h05, 32'h0000_0000);
    reqIdle(0);
    tick();

    // Load and back-to-back fetch.
    writeWord(0, 8'h00, 32'h012A_4020);
    writeWord(0, 8'h01, 32'h0253_8822);
    applyStimulus(0, 8'h00, 32'h012A_4020);
    checkOutput("b2b first rsp_valid", {31'b0, rsp_valid[0]}, 32'd1);
    checkOutput("b2b first rsp_instr", rsp_instr[0], 32'h012A_4020);
    applyStimulus(0, 8'h01, 32'h0253_8822);
    checkOutput("b2b second rsp_valid", {31'b0, rsp_valid[0]}, 32'd1);
    checkOutput("b2b second rsp_instr", rsp_instr[0], 32'h0253_8822);
    reqIdle(0);
    tick();
    checkOutput("drain rsp_valid", {31'b0, rsp_valid[0]}, 32'd0);
    checkOutput("drain rsp_instr hold", rsp_instr[0], 32'h0253_8822);

    // Back-pressure: response held, pending fetch of addr 1 blocked.
    rsp_ready[0] = 1'b0;
    applyStimulus(0, 8'h00, 32'h012A_4020);
    req_addr[0] = 8'h01;
    for (int c = 0; c < 4; c++) begin
      checkOutput("bp req_ready", {31'b0, req_ready[0]}, 32'd0);
      checkOutput("bp rsp_valid", {31'b0, rsp_valid[0]}, 32'd1);
      checkOutput("bp rsp_instr", rsp_instr[0], 32'h012A_4020);
      tick();
    end
    rsp_ready[0] = 1'b1;
    #1;
    checkOutput("bp release req_ready", {31'b0, req_ready[0]}, 32'd1);
    pushExp(0, 32'h0253_8822);
    tick();
    reqIdle(0);
    tick();

    // Read-first collision on addr 1.
    wr_en[0]     = 1'b1;
    wr_addr[0]   = 8'h01;
    wr_data[0]   = 32'hDEAD_BEEF;
    req_valid[0] = 1'b1;
    req_addr[0]  = 8'h01;
    #1;
    checkOutput("collision req_ready", {31'b0, req_ready[0]}, 32'd1);
    pushExp(0, 32'h0253_8822);
    tick();
    wr_en[0] = 1'b0;
    reqIdle(0);
    applyStimulus(0, 8'h01, 32'hDEAD_BEEF);
    reqIdle(0);
    tick();

    // Out of range on the DEPTH = 200 instance.
    writeWord(1, 8'd0,   32'h1111_1111);
    writeWord(1, 8'd199, 32'h2222_2222);
    writeWord(1, 8'd210, 32'h1234_5678);
    applyStimulus(1, 8'd0,   32'h1111_1111);
    applyStimulus(1, 8'd210, 32'h0000_0000);
    applyStimulus(1, 8'd199, 32'h2222_2222);
    reqIdle(1);
    repeat (2) tick();

    // Reset while a response is stalled, then a full re-clear.
    writeWord(0, 8'h00, 32'h012A_4020);
    rsp_ready[0] = 1'b0;
    applyStimulus(0, 8'h00, 32'h012A_4020);
    reqIdle(0);
    checkOutput("pre-reset rsp_valid", {31'b0, rsp_valid[0]}, 32'd1);
    rst = 1'b1;
    tick();
    checkOutput("mid reset rsp_valid", {31'b0, rsp_valid[0]}, 32'd0);
    checkOutput("mid reset init_done", {31'b0, init_done[0]}, 32'd0);
    exp_q0.delete();
    rsp_ready[0] = 1'b1;
    tick();
    rst = 1'b0;
    waitInit(0, cnt0);
    checkOutput("re-clear latency dut0", cnt0, 32'd256);
    applyStimulus(0, 8'h00, 32'h0000_0000);
    reqIdle(0);
    repeat (3) tick();

    checkOutput("scoreboard empty dut0", exp_q0.size(), 32'd0);
    checkOutput("scoreboard empty dut1", exp_q1.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
